// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the MIPS instruction encoder.
//   - cmd_op command codes (5-bit) accepted on the command port
//   - 6-bit primary opcodes and R-type function codes
//   - encoder FSM state encoding
//   - r_word(): packs an R-type instruction word
package mips_pkg;

  // Command codes presented on cmd_op; 21..31 are illegal.
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_JR   = 5'd8;
  localparam logic [4:0] OP_HAMD = 5'd9;
  localparam logic [4:0] OP_ADDI = 5'd10;
  localparam logic [4:0] OP_ANDI = 5'd11;
  localparam logic [4:0] OP_ORI  = 5'd12;
  localparam logic [4:0] OP_XORI = 5'd13;
  localparam logic [4:0] OP_LW   = 5'd14;
  localparam logic [4:0] OP_SW   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BNE  = 5'd17;
  localparam logic [4:0] OP_LUI  = 5'd18;
  localparam logic [4:0] OP_J    = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;

  // Primary opcodes (instruction bits [31:26]).
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes (instruction bits [5:0]).
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_HAMD = 6'h27;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_FULL  = 2'd3
  } state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] func);
    return {OPC_RTYPE, rs, rt, rd, shamt, func};
  endfunction

endpackage

// File: rtl/mips_word_pack.sv
// mips_word_pack: combinational packing of one command into a 32-bit MIPS word.
// Ports:
//   op_i      [4:0]  command code
//   rs_i/rt_i/rd_i [4:0] register fields
//   imm_i     [15:0] immediate (bits [4:0] are shamt for shifts)
//   target_i  [25:0] jump target
//   word_o    [31:0] encoded instruction (0 when illegal)
//   illegal_o        command code outside the supported set
module mips_word_pack
  import mips_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  // Field packing per command class; unused fields are forced to zero.
  always_comb begin
    word_o    = 32'd0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_ADD);
      OP_SUB:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SUB);
      OP_AND:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_AND);
      OP_OR:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_OR);
      OP_XOR:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_XOR);
      OP_HAMD: word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_HAMD);
      // Shifts take their amount from imm[4:0] and ignore rs.
      OP_SLL:  word_o = r_word(5'd0, rt_i, rd_i, imm_i[4:0], FN_SLL);
      OP_SRL:  word_o = r_word(5'd0, rt_i, rd_i, imm_i[4:0], FN_SRL);
      OP_SRA:  word_o = r_word(5'd0, rt_i, rd_i, imm_i[4:0], FN_SRA);
      OP_JR:   word_o = r_word(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_ADDI: word_o = {OPC_ADDI, rs_i, rt_i, imm_i};
      OP_ANDI: word_o = {OPC_ANDI, rs_i, rt_i, imm_i};
      OP_ORI:  word_o = {OPC_ORI,  rs_i, rt_i, imm_i};
      OP_XORI: word_o = {OPC_XORI, rs_i, rt_i, imm_i};
      OP_LW:   word_o = {OPC_LW,   rs_i, rt_i, imm_i};
      OP_SW:   word_o = {OPC_SW,   rs_i, rt_i, imm_i};
      OP_BEQ:  word_o = {OPC_BEQ,  rs_i, rt_i, imm_i};
      OP_BNE:  word_o = {OPC_BNE,  rs_i, rt_i, imm_i};
      OP_LUI:  word_o = {OPC_LUI,  5'd0, rt_i, imm_i};
      OP_J:    word_o = {OPC_J,   target_i};
      OP_JAL:  word_o = {OPC_JAL, target_i};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_encoder.sv
// mips_encoder: accepts encoding commands one at a time and writes the packed
// MIPS words to consecutive instruction-memory addresses starting at BASE_ADDR.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 restart program at BASE_ADDR (clears count, leaves DONE/FULL)
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op, cmd_rs/rt/rd, cmd_imm, cmd_target, cmd_last   command payload
//   imem_we/addr/data     instruction-memory write port (one-cycle pulse)
//   done, full, err       status: program ended, DEPTH reached, illegal command
//   count [6:0]           words written since start or reset
module mips_encoder
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_op,
  input  logic [4:0]  cmd_rs,
  input  logic [4:0]  cmd_rt,
  input  logic [4:0]  cmd_rd,
  input  logic [15:0] cmd_imm,
  input  logic [25:0] cmd_target,
  input  logic        cmd_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        done,
  output logic        full,
  output logic        err,
  output logic [6:0]  count
);

  state_e      state_q, state_d;
  logic [6:0]  count_q, count_d;
  logic [31:0] word_q, word_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic [31:0] packed_word_s;
  logic        illegal_s;

  mips_word_pack u_pack (
    .op_i      (cmd_op),
    .rs_i      (cmd_rs),
    .rt_i      (cmd_rt),
    .rd_i      (cmd_rd),
    .imm_i     (cmd_imm),
    .target_i  (cmd_target),
    .word_o    (packed_word_s),
    .illegal_o (illegal_s)
  );

  // State and datapath registers; reset clears everything, including an in-flight write.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= 7'd0;
      word_q  <= 32'd0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. start overrides the handshake; the WRITE cycle's
  // imem_we is driven by the current state, so a start there still lets the write out.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    last_d  = last_q;
    err_d   = 1'b0;
    if (start) begin
      state_d = ST_IDLE;
      count_d = 7'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (illegal_s) begin
              err_d = 1'b1;
            end else begin
              word_d  = packed_word_s;
              last_d  = cmd_last;
              state_d = ST_WRITE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WRITE: begin
          count_d = count_q + 7'd1;
          if (last_q) begin
            state_d = ST_DONE;
          end else if ((count_q + 7'd1) == 7'(DEPTH)) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        ST_FULL: state_d = ST_FULL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign imem_we   = (state_q == ST_WRITE);
  assign imem_addr = BASE_ADDR + {23'd0, count_q, 2'b00};
  assign imem_data = word_q;
  assign done      = (state_q == ST_DONE);
  assign full      = (state_q == ST_FULL);
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_mips_encoder.sv
// tb_mips_encoder: directed self-checking bench for mips_encoder (DEPTH=4).
module tb_mips_encoder;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset, start, cmd_valid, cmd_last;
  logic        cmd_ready, imem_we, done, full, err;
  logic [4:0]  cmd_op, cmd_rs, cmd_rt, cmd_rd;
  logic [15:0] cmd_imm;
  logic [25:0] cmd_target;
  logic [31:0] imem_addr, imem_data;
  logic [6:0]  count;

  int n_checks = 0;
  int n_fails  = 0;

  mips_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
    .done(done), .full(full), .err(err), .count(count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm,
                         input logic [25:0] tgt, input logic last);
    cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    cmd_imm = imm; cmd_target = tgt; cmd_last = last;
  endtask

  // Handshake one command, then check the write cycle and the count after it.
  task automatic send(input string tag, input logic [4:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last,
                      input logic [31:0] exp_addr, input logic [31:0] exp_data,
                      input logic [6:0] exp_count);
    set_cmd(op, rs, rt, rd, imm, tgt, last);
    chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_we"},   {31'd0, imem_we}, 32'd1);
    chk({tag, "_addr"}, imem_addr, exp_addr);
    chk({tag, "_data"}, imem_data, exp_data);
    tick();
    chk({tag, "_we_off"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_count"},  {25'd0, count}, {25'd0, exp_count});
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cmd_valid = 1'b0;
    set_cmd(5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_count", {25'd0, count}, 32'd0);
    chk("rst_we",    {31'd0, imem_we}, 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_data",  imem_data, 32'h0);
    chk("rst_flags", {29'd0, done, full, err}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // add rd=3 rs=1 rt=2
    send("add", OP_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 32'h0, 32'h0022_1820, 7'd1);
    do_start();
    chk("start_count", {25'd0, count}, 32'd0);

    // lw then sll (shamt from imm, rs ignored)
    send("lw",  OP_LW,  5'd0, 5'd2, 5'd0, 16'h0004, 26'd0, 1'b0, 32'h0, 32'h8C02_0004, 7'd1);
    send("sll", OP_SLL, 5'd7, 5'd1, 5'd2, 16'h0004, 26'd0, 1'b0, 32'h4, 32'h0001_1100, 7'd2);
    do_start();

    // beq then jal with last -> DONE
    send("beq", OP_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 1'b0, 32'h0, 32'h1022_FFFF, 7'd1);
    send("jal", OP_JAL, 5'd0, 5'd0, 5'd0, 16'd0, 26'd3, 1'b1, 32'h4, 32'h0C00_0003, 7'd2);
    chk("done",       {31'd0, done}, 32'd1);
    chk("done_ready", {31'd0, cmd_ready}, 32'd0);
    chk("done_full",  {31'd0, full}, 32'd0);
    do_start();
    chk("done_cleared", {31'd0, done}, 32'd0);

    // Illegal op: err pulse, no write
    set_cmd(5'd25, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("ill_err",   {31'd0, err}, 32'd1);
    chk("ill_we",    {31'd0, imem_we}, 32'd0);
    chk("ill_count", {25'd0, count}, 32'd0);
    chk("ill_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    chk("ill_err_off", {31'd0, err}, 32'd0);
    chk("ill_we2",     {31'd0, imem_we}, 32'd0);

    // Fill to DEPTH=4: sub, jr, lui, sra
    send("sub", OP_SUB, 5'd4, 5'd5, 5'd6, 16'h07C0, 26'd0, 1'b0, 32'h0, 32'h0085_3022, 7'd1);
    send("jr",  OP_JR,  5'd31, 5'd5, 5'd6, 16'h001F, 26'd0, 1'b0, 32'h4, 32'h03E0_0008, 7'd2);
    send("lui", OP_LUI, 5'd9, 5'd8, 5'd0, 16'h1234, 26'd0, 1'b0, 32'h8, 32'h3C08_1234, 7'd3);
    send("sra", OP_SRA, 5'd0, 5'd3, 5'd4, 16'h0002, 26'd0, 1'b0, 32'hC, 32'h0003_2083, 7'd4);
    chk("full",       {31'd0, full}, 32'd1);
    chk("full_ready", {31'd0, cmd_ready}, 32'd0);
    chk("full_done",  {31'd0, done}, 32'd0);
    set_cmd(OP_ADD, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0, 1'b0);
    cmd_valid = 1'b1;
    tick();
    chk("full_nowe",   {31'd0, imem_we}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("full_nowe2",  {31'd0, imem_we}, 32'd0);
    chk("full_count",  {25'd0, count}, 32'd4);
    do_start();
    chk("restart_count", {25'd0, count}, 32'd0);
    chk("restart_full",  {31'd0, full}, 32'd0);
    send("ori", OP_ORI, 5'd2, 5'd3, 5'd0, 16'hABCD, 26'd0, 1'b0, 32'h0, 32'h3443_ABCD, 7'd1);

    // start during WRITE: the write still happens, then count clears
    set_cmd(OP_J, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3FF_FFFF, 1'b0);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    start = 1'b1;
    chk("sw_we",   {31'd0, imem_we}, 32'd1);
    chk("sw_addr", imem_addr, 32'h4);
    chk("sw_data", imem_data, 32'h0BFF_FFFF);
    tick();
    start = 1'b0;
    chk("sw_count", {25'd0, count}, 32'd0);
    chk("sw_ready", {31'd0, cmd_ready}, 32'd1);

    // reset during WRITE aborts
    send("xori", OP_XORI, 5'd1, 5'd1, 5'd0, 16'h00FF, 26'd0, 1'b0, 32'h0, 32'h3821_00FF, 7'd1);
    set_cmd(OP_HAMD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("rw_we",   {31'd0, imem_we}, 32'd1);
    chk("rw_data", imem_data, 32'h0022_1827);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_we_off", {31'd0, imem_we}, 32'd0);
    chk("rw_addr",   imem_addr, 32'h0);
    chk("rw_data0",  imem_data, 32'h0);
    chk("rw_count",  {25'd0, count}, 32'd0);
    chk("rw_flags",  {29'd0, done, full, err}, 32'd0);
    chk("rw_ready",  {31'd0, cmd_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mips_encoder.md
MIPS_ENCODER -- requirements
Module: mips_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written.
REQ-002 SHALL have parameter DEPTH, default 64: maximum number of words written per program.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: restarts the address at BASE_ADDR and leaves DONE/FULL.
REQ-006 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): the command handshake.
REQ-007 SHALL have port cmd_op, input, 5: instruction code (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 jr, 9 hamd, 10 addi, 11 andi, 12 ori, 13 xori, 14 lw, 15 sw, 16 beq, 17 bne, 18 lui, 19 j, 20 jal); codes 21-31 are illegal.
REQ-008 SHALL have ports cmd_rs, cmd_rt and cmd_rd, input, 5 each: register fields.
REQ-009 SHALL have port cmd_imm, input, 16: immediate; bits [4:0] give shamt for shifts.
REQ-010 SHALL have port cmd_target, input, 26: jump target; cmd_last, input, 1: final command of the program.
REQ-011 SHALL have outputs imem_we (1), imem_addr (32) and imem_data (32): the instruction-memory write port.
REQ-012 SHALL have outputs done (1), full (1), err (1), and count (7): words written since start or reset.

Function
REQ-013 SHALL implement states IDLE, WRITE, DONE and FULL; cmd_ready=1 only in IDLE.
REQ-014 SHALL, in IDLE on cmd_valid&cmd_ready with a legal op, register the encoded word and go to WRITE.
REQ-015 SHALL, in WRITE, assert imem_we for exactly one cycle, with imem_addr = BASE_ADDR + 4*count and the registered word; the latency from handshake to imem_we is one cycle.
REQ-016 SHALL increment count at the end of WRITE; the next state is DONE if the command was cmd_last, else FULL if count reaches DEPTH, else IDLE.
REQ-017 SHALL encode R-type as {6'b0, rs, rt, rd, shamt, func}, with func 20/22/24/25/26/00/02/03/08/27 (hex) for add/sub/and/or/xor/sll/srl/sra/jr/hamd.
REQ-018 SHALL force shamt=0 for non-shift R-type, rs=0 for shifts, and rt=rd=shamt=0 for jr.
REQ-019 SHALL encode I-type as {op, rs, rt, imm}, with op 08/0C/0D/0E/23/2B/04/05/0F (hex) for addi/andi/ori/xori/lw/sw/beq/bne/lui; rs SHALL be 0 for lui.
REQ-020 SHALL encode j as {6'h02, target} and jal as {6'h03, target}.
REQ-021 SHALL, on an illegal op accepted in IDLE, pulse err for one cycle, write nothing, leave count unchanged and stay in IDLE.
REQ-022 SHALL hold done=1 in DONE and full=1 in FULL, with cmd_ready=0 in both states.
REQ-023 SHALL, on start in any state, clear count and enter IDLE next cycle; a start during WRITE SHALL still complete that write (imem_we=1) before clearing.
REQ-024 SHALL give reset priority over start and over any handshake.

Reset
REQ-025 SHALL, on reset, enter IDLE with count=0, imem_we=0, imem_addr=BASE_ADDR, imem_data=0, done=0, full=0 and err=0.
REQ-026 SHALL, on reset during WRITE, abort the write: imem_we=0 in the following cycle.

Structure
REQ-027 SHALL place the cmd_op code constants, opcode constants, func constants and state encodings in shared package mips_pkg, also used by the decode unit.
REQ-028 SHALL hold the combinational field packing in sub-module mips_word_pack (inputs: op code and fields; outputs: word, illegal); the FSM, counter and registers SHALL live in mips_encoder.

Verification
REQ-029 SHALL cover: add rd=3 rs=1 rt=2 -> next cycle imem_we=1, imem_addr=0x0, imem_data=0x00221820.
REQ-030 SHALL cover: lw rt=2 rs=0 imm=4 followed by sll rd=2 rt=1 shamt=4 -> 0x8C020004 at 0x0, then 0x00011100 at 0x4.
REQ-031 SHALL cover: beq rs=1 rt=2 imm=0xFFFF, then jal target=3 with cmd_last=1 -> 0x1022FFFF and 0x0C000003; then done=1, cmd_ready=0 and count=2.
REQ-032 SHALL cover: cmd_op=25 -> err pulses one cycle, no imem_we, count unchanged, cmd_ready back to 1.
REQ-033 SHALL cover: DEPTH=4 with 4 legal commands -> full=1 after the 4th write; a 5th cmd_valid is not accepted; start -> count=0 and the next write goes to BASE_ADDR.
REQ-034 SHALL cover: reset asserted in the WRITE cycle -> no imem_we in the following cycle, all outputs at reset values.
